ram1_uart_bus_ctrl: RTL
=======================

# ram1_uart_bus_ctrl

Sequencing controller for the board-level RAM1/UART shared bus. It takes single-word read/write requests from the CPU data-memory stage and decodes them: addresses 0xBF00/0xBF01 go to the serial port, all others go to RAM1. It then drives the multi-cycle strobe sequences for the selected device. RAM1 and the UART share `ram1_data`, so RAM1 is kept disabled for the whole of any UART cycle.

## Interface
- `DATA_W`, 16, data word width (`DATA_BUS`)
- `ADDR_W`, 18, RAM1 address width (`ADDR_BUS`)
- `UART_DATA_ADDR`, 16'hBF00, serial data register address
- `UART_STAT_ADDR`, 16'hBF01, serial status register address

Ports:
- `clk` in 1: single clock, rising edge (the board's 50 MHz clock)
- `rst` in 1: asynchronous, active-low reset
- `req` in 1: access request, sampled only in IDLE
- `wr` in 1: 1 = write, 0 = read; captured with `req`
- `addr` in 16: word address; captured with `req`
- `wdata` in DATA_W: write data; captured with `req`
- `rdata` out DATA_W: read result, valid while `ack`=1 and held until the next read completes
- `ack` out 1: one-cycle completion pulse
- `busy` out 1: high from acceptance through the `ack` cycle
- `ram1_data` inout DATA_W: shared RAM1/UART data bus
- `ram1_addr` out ADDR_W: RAM1 address
- `ram1_en`, `ram1_oe`, `ram1_we` out 1 each: active-low RAM1 strobes
- `rdn`, `wrn` out 1 each: active-low UART read/write strobes
- `tsre`, `tbre`, `data_ready` in 1 each: asynchronous UART status inputs

## Operation
- **Status synchronizers.** `tsre`, `tbre` and `data_ready` each pass through a 2-flop synchronizer.
  - tx_ready = tsre_s & tbre_s.
- **Address decode** (on the captured address):
  - == UART_DATA_ADDR: UART data cycle.
  - == UART_STAT_ADDR: status cycle.
  - anything else: RAM cycle with `ram1_addr` = {2'b00, addr}.
- **States and transitions:**
  - IDLE: `req`=1 moves to RD1/WR1 (RAM), URD1/UWR1 (UART data) or STAT. `req`=0 stays in IDLE.
  - RAM read: RD1 → RD2 → DONE. `ram1_en`=0 and `ram1_oe`=0 in RD1 and RD2; bus is Z; `ram1_data` is latched into `rdata` at the end of RD2.
  - RAM write: WR1 → WR2 → WR3 → DONE. `ram1_en`=0 in all three states; the bus is driven with wdata in all three; `ram1_we`=0 only in WR2.
  - UART read: URD1 → URD2 → DONE. `rdn`=0 in URD1 and URD2; bus is Z; data is latched at the end of URD2.
  - UART write: UWR1 → UWR2 → UWR3 → DONE. The bus is driven with wdata in all three states; `wrn`=0 only in UWR2.
  - STAT: `rdata` ← {14'b0, data_ready_s, tx_ready}, then → DONE.
  - DONE: `ack`=1, all strobes deasserted, bus Z, then → IDLE.
- **RAM1 isolation.** `ram1_en`=1 in every UART and STAT state; `ram1_oe`/`ram1_we` are never low while `ram1_en`=1.
- **Bus-drive rule.** `ram1_data` is driven only in WR1–WR3 and UWR1–UWR3.
- **No UART flow control in hardware.** A UART write is performed regardless of tx_ready; software polls STAT first. A UART read with data_ready_s=0 still completes and returns the bus value.
- **Blocked requests.** `req` while `busy`=1 is ignored, not queued. The requester holds `req` until it sees `ack`. `req` seen in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- **Write results.** Writes leave `rdata` unchanged.

## Timing
- Cycle 0 is the IDLE cycle where `req`=1 is sampled. `ack` rises:
  - cycle 3 for RAM read and UART read;
  - cycle 4 for RAM write and UART write;
  - cycle 2 for STAT.
- `busy` rises in cycle 1 and falls after the `ack` cycle.
- Back-to-back accesses: the next access can be accepted one cycle after `ack`.
- `ram1_addr` is registered. It is stable from cycle 1 through DONE and holds its last value in IDLE.
- Status inputs add 2 cycles of synchronizer latency before STAT reflects a change.
- **Reset values:**
  - `ram1_en`/`ram1_oe`/`ram1_we`/`rdn`/`wrn` = 1.
  - `ram1_data` = Z.
  - `ram1_addr` = 0, `rdata` = 0, `ack` = 0, `busy` = 0.
  - State = IDLE; synchronizers = 0.
- **Reset mid-operation:** all strobes deassert and the bus releases immediately (asynchronously). No `ack` is issued for the aborted access.

## Test plan
- **RAM write then read.** Write addr 0x1234, wdata 0xBEEF, against a RAM model, then read 0x1234.
  - `ram1_we` is low exactly 1 cycle (WR2) with `ram1_addr`=0x01234.
  - Write `ack` at cycle 4; read `ack` at cycle 3 with `rdata`=0xBEEF.
- **UART write.** Write 0xBF00 with wdata 0x0041.
  - `wrn` is low exactly 1 cycle with bus=0x0041.
  - `ram1_en`=1 throughout; `ack` at cycle 4.
- **Status and UART read.** Set tsre=tbre=1, data_ready=1, then read 0xBF01 followed by 0xBF00 (model drives 0x005A on `rdn`=0).
  - Status read returns `rdata`=0x0003.
  - Data read has `rdn` low 2 cycles and returns `rdata`=0x005A.
- **Request while busy.** Pulse a second `req` (read, 0x0002) during a RAM write.
  - It is ignored: no second access until `busy` falls and `req` is re-sampled.
  - Held `req` through DONE is accepted one cycle after `ack`.
- **Reset mid-write.** Assert `rst`=0 in WR2.
  - Same cycle: `ram1_we`=1, `ram1_en`=1, bus Z.
  - No `ack`; after release the block is in IDLE with `busy`=0.
- **Bus contention check.** Across a randomized 1000-access mix:
  - `ram1_en`=0 never coincides with `rdn`=0 or `wrn`=0.
  - `ram1_oe`=0 never coincides with the controller driving `ram1_data`.

Source files
------------

// File: rtl/ram1_uart_bus_ctrl.sv
// ram1_uart_bus_ctrl: sequences single-word CPU accesses onto the shared
// RAM1/UART data bus. Addresses UART_DATA_ADDR/UART_STAT_ADDR select the
// serial port, every other address selects RAM1. All strobes are registered
// and active-low; RAM1 stays disabled for the whole of any UART or status cycle.
module ram1_uart_bus_ctrl #(
  parameter int          DATA_W         = 16,
  parameter int          ADDR_W         = 18,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  inout  wire  [DATA_W-1:0] ram1_data,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic              rdn,
  output logic              wrn,
  input  logic              tsre,
  input  logic              tbre,
  input  logic              data_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD1, S_RD2,
    S_WR1, S_WR2, S_WR3,
    S_URD1, S_URD2,
    S_UWR1, S_UWR2, S_UWR3,
    S_STAT,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [2:0]        sync1_reg;
  logic [2:0]        sync2_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              drive_reg;
  logic              en_reg;
  logic              oe_reg;
  logic              we_reg;
  logic              rdn_reg;
  logic              wrn_reg;
  logic              ack_reg;
  logic              busy_reg;

  logic              tx_ready;
  logic              data_ready_s;
  logic [DATA_W-1:0] status_word;

  // Bit order in the synchronizer vectors: {data_ready, tbre, tsre}
  assign tx_ready     = sync2_reg[0] & sync2_reg[1];
  assign data_ready_s = sync2_reg[2];
  assign status_word  = {{(DATA_W-2){1'b0}}, data_ready_s, tx_ready};

  // The controller only drives the shared bus during write states
  assign ram1_data = drive_reg ? wdata_reg : {DATA_W{1'bz}};

  assign rdata     = rdata_reg;
  assign ack       = ack_reg;
  assign busy      = busy_reg;
  assign ram1_addr = addr_reg;
  assign ram1_en   = en_reg;
  assign ram1_oe   = oe_reg;
  assign ram1_we   = we_reg;
  assign rdn       = rdn_reg;
  assign wrn       = wrn_reg;

  // Two-flop synchronizers for the asynchronous UART status lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {data_ready, tbre, tsre};
      sync2_reg <= sync1_reg;
    end
  end

  // Access sequencer; each transition also loads the strobe levels of the
  // state being entered so every bus-facing output comes straight from a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      wdata_reg <= '0;
      rdata_reg <= '0;
      addr_reg  <= '0;
      drive_reg <= 1'b0;
      en_reg    <= 1'b1;
      oe_reg    <= 1'b1;
      we_reg    <= 1'b1;
      rdn_reg   <= 1'b1;
      wrn_reg   <= 1'b1;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (req) begin
            busy_reg  <= 1'b1;
            wdata_reg <= wdata;
            if (addr == UART_DATA_ADDR) begin
              if (wr) begin
                state_reg <= S_UWR1;
                drive_reg <= 1'b1;
              end else begin
                state_reg <= S_URD1;
                rdn_reg   <= 1'b0;
              end
            end else if (addr == UART_STAT_ADDR) begin
              state_reg <= S_STAT;
            end else begin
              // RAM address is only updated for RAM cycles and holds otherwise
              addr_reg <= {{(ADDR_W-16){1'b0}}, addr};
              en_reg   <= 1'b0;
              if (wr) begin
                state_reg <= S_WR1;
                drive_reg <= 1'b1;
              end else begin
                state_reg <= S_RD1;
                oe_reg    <= 1'b0;
              end
            end
          end
        end
        S_RD1: state_reg <= S_RD2;
        S_RD2: begin
          state_reg <= S_DONE;
          en_reg    <= 1'b1;
          oe_reg    <= 1'b1;
          rdata_reg <= ram1_data;
          ack_reg   <= 1'b1;
        end
        S_WR1: begin
          state_reg <= S_WR2;
          we_reg    <= 1'b0;
        end
        S_WR2: begin
          state_reg <= S_WR3;
          we_reg    <= 1'b1;
        end
        S_WR3: begin
          state_reg <= S_DONE;
          en_reg    <= 1'b1;
          drive_reg <= 1'b0;
          ack_reg   <= 1'b1;
        end
        S_URD1: state_reg <= S_URD2;
        S_URD2: begin
          state_reg <= S_DONE;
          rdn_reg   <= 1'b1;
          rdata_reg <= ram1_data;
          ack_reg   <= 1'b1;
        end
        S_UWR1: begin
          state_reg <= S_UWR2;
          wrn_reg   <= 1'b0;
        end
        S_UWR2: begin
          state_reg <= S_UWR3;
          wrn_reg   <= 1'b1;
        end
        S_UWR3: begin
          state_reg <= S_DONE;
          drive_reg <= 1'b0;
          ack_reg   <= 1'b1;
        end
        S_STAT: begin
          state_reg <= S_DONE;
          rdata_reg <= status_word;
          ack_reg   <= 1'b1;
        end
        S_DONE: begin
          // A request present here is deliberately not accepted until IDLE
          state_reg <= S_IDLE;
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
